multiply_add_unit: RTL and testbench
====================================

Name: multiply_add_unit

Overview:
Sequential shift-and-add multiplier with an addend. It computes product = left_op * right_op + addend, one multiplier bit per cycle. It is the inverse of the divide path: feeding a quotient, divisor and modulus back in reconstructs the dividend. It is used to check and recompose division results in the redundancy datapath, and it uses the same enable/valid hold-until-release handshake as the divide unit.

Parameters:
WORD_WIDTH, 8, operand width in bits; must be >= 2.

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
enable  input  1  request; sampled in IDLE, and in DONE as the release
left_op  input  WORD_WIDTH  multiplicand, unsigned
right_op  input  WORD_WIDTH  multiplier, unsigned
addend  input  WORD_WIDTH  unsigned addend
busy  output  1  high in CALC and DONE
valid  output  1  result valid
prod_lo  output  WORD_WIDTH  result bits [WORD_WIDTH-1:0]
prod_hi  output  WORD_WIDTH  result bits [2*WORD_WIDTH-1:WORD_WIDTH]
overflow  output  1  high when prod_hi != 0, i.e. the result does not fit in WORD_WIDTH bits

Behaviour:
- Clock and reset: one clock domain (clk). reset_n is asynchronous and active-low. Reset forces state IDLE and clears all registers to 0. After reset: busy=0, valid=0, prod_lo=0, prod_hi=0, overflow=0.
- Internal registers:
  - acc: 2W bits.
  - mcand: 2W bits.
  - mplier: W bits.
  - count: clog2(W+1) bits.
- Outputs are registered. prod_lo/prod_hi expose acc. overflow is derived from registered acc.
- State machine, three states: IDLE, CALC, DONE.
- IDLE, with enable=1 at edge T0:
  - acc <= zero-extended addend.
  - mcand <= zero-extended left_op.
  - mplier <= right_op.
  - count <= 0.
  - Next state CALC.
- IDLE, with enable=0: remain in IDLE. acc holds the previous result, so prod_lo/prod_hi/overflow stay stable with valid=0.
- CALC, each cycle:
  - if mplier[0], acc <= acc + mcand (2W-bit add; no carry out is possible).
  - mcand <= mcand << 1.
  - mplier <= mplier >> 1.
  - count <= count + 1.
  - When count == W-1, this cycle performs the last iteration, and on the same edge the state goes to DONE and valid <= 1.
- Latency: valid rises on edge T0+W, i.e. W iterations after the capture edge. Example: W=8 gives valid high 8 cycles after capture.
- DONE, with enable=1: hold the result with valid=1.
- DONE, with enable=0: valid <= 0 and next state IDLE. The result stays on prod_lo/prod_hi.
- Inputs are ignored outside IDLE. Changes to left_op, right_op or addend during CALC/DONE have no effect.
- enable deasserted during CALC: the computation still completes. valid then pulses for exactly one cycle, because DONE sees enable=0 and releases.
- Back-to-back operations: enable held high through DONE, then dropped for one cycle, returns to IDLE. The minimum spacing between capture edges is W+2 cycles.
- Range: result <= (2^W-1)^2 + 2^W-1 = 2^(2W) - 2^W, so 2W bits always suffice.
- Reset mid-operation (CALC or DONE): abort immediately to IDLE with all outputs 0. No partial result survives.
- right_op = 0: the result equals addend after the full W cycles. There is no early termination, so latency is constant.

Test Plan:
- W=8, left_op=13, right_op=11, addend=7, enable held high -> valid rises exactly 8 edges after capture; prod_hi=0x00, prod_lo=150 (0x96), overflow=0, busy=1 throughout CALC/DONE.
- W=8, left_op=255, right_op=255, addend=255 -> prod_hi=0xFF, prod_lo=0x00 (65280), overflow=1.
- Division round trip: left_op=23, right_op=9, addend=4 -> result 211 (0xD3), overflow=0. Also left_op=0, right_op=200, addend=0 -> result 0, latency still 8.
- Pulse enable for one cycle only, then change operands during CALC -> result uses the captured operands; valid is high for exactly one cycle, then the unit returns to IDLE and the result persists with valid=0.
- Assert reset_n low 4 cycles into CALC -> busy, valid, prod_lo, prod_hi and overflow are all 0 immediately (asynchronous). A new request after release gives a correct result with full latency.
- Two back-to-back requests (3*5+1, then 100*3+44), each released after valid -> results 16, then 344 (prod_hi=0x01, prod_lo=0x58, overflow=1). The second capture occurs no earlier than the W+2 spacing.

Source files
------------

// File: rtl/multiply_add_unit.sv
// Sequential shift-and-add multiplier with addend: product = left_op * right_op + addend.
// One multiplier bit per cycle, enable/valid handshake held until released in DONE.
module multiply_add_unit #(
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [WORD_WIDTH-1:0] left_op,
    input  logic [WORD_WIDTH-1:0] right_op,
    input  logic [WORD_WIDTH-1:0] addend,
    output logic                  busy,
    output logic                  valid,
    output logic [WORD_WIDTH-1:0] prod_lo,
    output logic [WORD_WIDTH-1:0] prod_hi,
    output logic                  overflow
);

    localparam int CW = $clog2(WORD_WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]              state;
    logic [2*WORD_WIDTH-1:0] acc;
    logic [2*WORD_WIDTH-1:0] mcand;
    logic [WORD_WIDTH-1:0]   mplier;
    logic [CW-1:0]           count;
    logic                    last_iter;

    assign last_iter = (count == CW'(WORD_WIDTH - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            valid  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        acc    <= {{WORD_WIDTH{1'b0}}, addend};
                        mcand  <= {{WORD_WIDTH{1'b0}}, left_op};
                        mplier <= right_op;
                        count  <= '0;
                        state  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    // Result is bounded by 2^(2W) - 2^W, so this add never carries out.
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (last_iter) begin
                        state <= ST_DONE;
                        valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!enable) begin
                        valid <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = (state != ST_IDLE);
    assign prod_lo  = acc[WORD_WIDTH-1:0];
    assign prod_hi  = acc[2*WORD_WIDTH-1:WORD_WIDTH];
    assign overflow = |acc[2*WORD_WIDTH-1:WORD_WIDTH];

endmodule

// File: tb/tb_multiply_add_unit.sv
// Self-checking bench for multiply_add_unit: directed table, hand sequences for
// pulse/reset/back-to-back corners, and random operands against an arithmetic model.
module tb_multiply_add_unit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         enable = 1'b0;
    logic [W-1:0] left_op = '0;
    logic [W-1:0] right_op = '0;
    logic [W-1:0] addend = '0;
    logic         busy;
    logic         valid;
    logic [W-1:0] prod_lo;
    logic [W-1:0] prod_hi;
    logic         overflow;

    int compared = 0;
    int mismatched = 0;
    int cycle = 0;

    multiply_add_unit #(.WORD_WIDTH(W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .left_op  (left_op),
        .right_op (right_op),
        .addend   (addend),
        .busy     (busy),
        .valid    (valid),
        .prod_lo  (prod_lo),
        .prod_hi  (prod_hi),
        .overflow (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic [W-1:0]   l;
        logic [W-1:0]   r;
        logic [W-1:0]   a;
        logic [2*W-1:0] exp;
        logic           ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] model(input int unsigned l, input int unsigned r,
                                             input int unsigned a);
        int unsigned full;
        full = l * r + a;
        return full[2*W-1:0];
    endfunction

    // Drive a request at the negedge; returns right after the capture edge.
    task automatic start(input logic [W-1:0] l, input logic [W-1:0] r, input logic [W-1:0] a);
        @(negedge clk);
        left_op  = l;
        right_op = r;
        addend   = a;
        enable   = 1'b1;
        @(posedge clk);
    endtask

    // Counts edges after capture until valid is seen (bounded).
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) check("busy_in_calc", busy, 1);
        end while (!valid && n < 4 * W);
        if (!valid) check("valid_timeout", valid, 1);
    endtask

    task automatic run_op(input string name, input logic [W-1:0] l, input logic [W-1:0] r,
                          input logic [W-1:0] a, input logic [2*W-1:0] exp, input logic ovf);
        int n;
        start(l, r, a);
        wait_valid(n);
        check({name, "_latency"}, n, W);
        check({name, "_prod"}, {prod_hi, prod_lo}, exp);
        check({name, "_ovf"}, overflow, ovf);
        check({name, "_busy_done"}, busy, 1);
        @(posedge clk);
        @(negedge clk);
        check({name, "_valid_held"}, valid, 1);
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({name, "_valid_released"}, valid, 0);
        check({name, "_busy_idle"}, busy, 0);
        check({name, "_prod_persist"}, {prod_hi, prod_lo}, exp);
    endtask

    initial begin
        int n;
        int t0;
        int t1;
        logic [W-1:0]   rl, rr, ra;
        logic [2*W-1:0] rexp;

        vecs[0] = '{l: 8'd13,  r: 8'd11,  a: 8'd7,   exp: 16'd150,   ovf: 1'b0};
        vecs[1] = '{l: 8'd255, r: 8'd255, a: 8'd255, exp: 16'd65280, ovf: 1'b1};
        vecs[2] = '{l: 8'd23,  r: 8'd9,   a: 8'd4,   exp: 16'd211,   ovf: 1'b0};
        vecs[3] = '{l: 8'd0,   r: 8'd200, a: 8'd0,   exp: 16'd0,     ovf: 1'b0};
        vecs[4] = '{l: 8'd3,   r: 8'd5,   a: 8'd1,   exp: 16'd16,    ovf: 1'b0};
        vecs[5] = '{l: 8'd100, r: 8'd3,   a: 8'd44,  exp: 16'd344,   ovf: 1'b1};
        vecs[6] = '{l: 8'd77,  r: 8'd0,   a: 8'd9,   exp: 16'd9,     ovf: 1'b0};
        vecs[7] = '{l: 8'd128, r: 8'd128, a: 8'd0,   exp: 16'd16384, ovf: 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_prod", {prod_hi, prod_lo}, 0);
        check("rst_ovf", overflow, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_enable_busy", busy, 0);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].l, vecs[i].r, vecs[i].a, vecs[i].exp, vecs[i].ovf);
        end

        // One-cycle enable pulse; operands change during CALC
        start(8'd23, 8'd9, 8'd4);
        @(negedge clk);
        enable   = 1'b0;
        left_op  = 8'($urandom);
        right_op = 8'($urandom);
        addend   = 8'($urandom);
        wait_valid(n);
        check("pulse_latency", n, W);
        check("pulse_prod", {prod_hi, prod_lo}, 211);
        @(posedge clk);
        @(negedge clk);
        check("pulse_valid_one_cycle", valid, 0);
        check("pulse_busy_idle", busy, 0);
        repeat (3) @(negedge clk);
        check("pulse_prod_persist", {prod_hi, prod_lo}, 211);
        check("pulse_valid_low", valid, 0);

        // Asynchronous reset 4 cycles into CALC
        start(8'd200, 8'd255, 8'd9);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("pre_reset_busy", busy, 1);
        #1 reset_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_valid", valid, 0);
        check("midrst_prod", {prod_hi, prod_lo}, 0);
        check("midrst_ovf", overflow, 0);
        enable = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        run_op("after_reset", 8'd13, 8'd11, 8'd7, 16'd150, 1'b0);

        // Back-to-back with a single release cycle
        start(8'd3, 8'd5, 8'd1);
        @(negedge clk);
        t0 = cycle;
        wait_valid(n);
        check("b2b_first_prod", {prod_hi, prod_lo}, 16);
        enable = 1'b0;
        @(negedge clk);
        enable   = 1'b1;
        left_op  = 8'd100;
        right_op = 8'd3;
        addend   = 8'd44;
        @(posedge clk);
        @(negedge clk);
        t1 = cycle;
        check("b2b_spacing", t1 - t0, W + 2);
        wait_valid(n);
        check("b2b_second_latency", n, W);
        check("b2b_second_prod", {prod_hi, prod_lo}, 344);
        check("b2b_second_hi", prod_hi, 8'h01);
        check("b2b_second_ovf", overflow, 1);
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("b2b_release", valid, 0);

        // Random operands against the arithmetic model
        for (int k = 0; k < 20; k++) begin
            rl   = 8'($urandom);
            rr   = 8'($urandom);
            ra   = 8'($urandom);
            rexp = model(rl, rr, ra);
            run_op($sformatf("rand%0d", k), rl, rr, ra, rexp, rexp >= (2 ** W));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
